// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, status codes and instruction-format helpers.
package y86_pkg;

    localparam int unsigned PC_W      = 64;
    localparam int unsigned BUF_BYTES = 10;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_t;

    // Instruction length in bytes; invalid icodes occupy one byte.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            RRMOVQ, OPQ, PUSHQ, POPQ: instr_len = 4'd2;
            JXX, CALL:                instr_len = 4'd9;
            IRMOVQ, RMMOVQ, MRMOVQ:   instr_len = 4'd10;
            default:                  instr_len = 4'd1;
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] ic);
        case (ic)
            RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ: has_regs = 1'b1;
            default:                                          has_regs = 1'b0;
        endcase
    endfunction

    // Byte offset of valC: 1 or 2, or 0 when the instruction has no constant.
    function automatic logic [1:0] valc_off(input logic [3:0] ic);
        case (ic)
            JXX, CALL:              valc_off = 2'd1;
            IRMOVQ, RMMOVQ, MRMOVQ: valc_off = 2'd2;
            default:                valc_off = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_assemble.sv
// Instruction byte buffer and field split; uncaptured bytes read as zero.
module fetch_assemble
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        wrEn,
    input  logic [3:0]  wrIdx,
    input  logic [7:0]  wrData,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC
);

    logic [7:0] byteBuf [BUF_BYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_BYTES; i++) byteBuf[i] <= 8'h00;
        end else if (clear) begin
            for (int i = 0; i < BUF_BYTES; i++) byteBuf[i] <= 8'h00;
        end else if (wrEn && (wrIdx < 4'(BUF_BYTES))) begin
            byteBuf[wrIdx] <= wrData;
        end
    end

    assign icode = byteBuf[0][7:4];
    assign ifun  = byteBuf[0][3:0];

    // Register specifier defaults to F when the format has no register byte.
    always_comb begin
        rA   = 4'hF;
        rB   = 4'hF;
        valC = '0;
        if (has_regs(byteBuf[0][7:4])) begin
            rA = byteBuf[1][7:4];
            rB = byteBuf[1][3:0];
        end
        case (valc_off(byteBuf[0][7:4]))
            2'd1:    for (int i = 0; i < 8; i++) valC[8*i +: 8] = byteBuf[i+1];
            2'd2:    for (int i = 0; i < 8; i++) valC[8*i +: 8] = byteBuf[i+2];
            default: valC = '0;
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// SEQ fetch unit: PC register, byte-serial memory handshake and instruction status.
module fetch_seq
    import y86_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_load,
    input  logic [63:0] new_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic [63:0] pc,
    output logic        instr_valid,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  stat
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, STOP} state_t;

    state_t      state;
    logic [63:0] pcReg;
    logic [63:0] valPReg;
    logic [3:0]  byteIdx;
    stat_t       statReg;

    logic [3:0]  bufIcode;
    logic [3:0]  curIcode;
    logic [3:0]  curLen;
    logic        lastByte;
    logic        bufWr;
    logic        bufClr;

    // Byte 0 decides the length in the same cycle it arrives.
    assign curIcode = (byteIdx == 4'd0) ? mem_rdata[7:4] : bufIcode;
    assign curLen   = instr_len(curIcode);
    assign lastByte = (byteIdx + 4'd1) == curLen;
    assign bufWr    = (state == FETCH) && mem_ack && !mem_err;
    assign bufClr   = (state == VALID) && pc_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pcReg   <= PC_RESET;
            valPReg <= '0;
            byteIdx <= '0;
            statReg <= AOK;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (mem_ack) begin
                        if (mem_err) begin
                            statReg <= ADR;
                            state   <= STOP;
                        end else begin
                            byteIdx <= byteIdx + 4'd1;
                            if (lastByte) begin
                                valPReg <= pcReg + 64'(curLen);
                                if (curIcode == HALT) begin
                                    statReg <= HLT;
                                    state   <= STOP;
                                end else if (curIcode > POPQ) begin
                                    statReg <= INS;
                                    state   <= STOP;
                                end else begin
                                    statReg <= AOK;
                                    state   <= VALID;
                                end
                            end
                        end
                    end
                end
                VALID: begin
                    if (pc_load) begin
                        pcReg   <= new_pc;
                        valPReg <= '0;
                        byteIdx <= '0;
                        statReg <= AOK;
                        state   <= FETCH;
                    end
                end
                STOP:    state <= STOP;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_assemble uAssemble (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bufClr),
        .wrEn   (bufWr),
        .wrIdx  (byteIdx),
        .wrData (mem_rdata),
        .icode  (bufIcode),
        .ifun   (ifun),
        .rA     (rA),
        .rB     (rB),
        .valC   (valC)
    );

    assign icode       = bufIcode;
    assign mem_req     = (state == FETCH);
    assign mem_addr    = pcReg + 64'(byteIdx);
    assign pc          = pcReg;
    assign valP        = valPReg;
    assign stat        = statReg;
    assign instr_valid = (state == VALID) || (state == STOP);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a byte memory model and configurable wait states.
module tb_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        pc_load;
    logic [63:0] new_pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic [63:0] pc;
    logic        instr_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;

    int          nChecks;
    int          nErrors;
    int          waitStates;
    int          waitCnt;
    int          cyc;
    logic        errEn;
    logic [63:0] errAddr;
    logic [63:0] constWord;
    logic [7:0]  memArr [1024];

    fetch_seq #(.PC_RESET(64'd0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_load     (pc_load),
        .new_pc      (new_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .pc          (pc),
        .instr_valid (instr_valid),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .stat        (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after waitStates idle request cycles.
    assign mem_ack   = mem_req && (waitCnt == waitStates);
    assign mem_err   = errEn && (mem_addr == errAddr);
    assign mem_rdata = memArr[mem_addr[9:0]];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) waitCnt <= 0;
        else                     waitCnt <= waitCnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitValid(input int budget, output int cycles);
        cycles = 0;
        while (!instr_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("valid_timeout", 64'(instr_valid), 64'd1);
    endtask

    task automatic pcLoad(input logic [63:0] a);
        pc_load = 1'b1;
        new_pc  = a;
        tick();
        pc_load = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nChecks = 0;
        nErrors = 0;
        for (int i = 0; i < 1024; i++) memArr[i] = 8'h00;
        memArr[10'h000] = 8'h10;
        memArr[10'h001] = 8'h70;
        memArr[10'h002] = 8'h40;
        memArr[10'h040] = 8'h60;
        memArr[10'h041] = 8'h12;
        memArr[10'h100] = 8'h30;
        memArr[10'h101] = 8'hF3;
        constWord = 64'h1122334455667788;
        for (int i = 0; i < 8; i++) memArr[10'h102 + i] = constWord[8*i +: 8];
        memArr[10'h120] = 8'h00;
        memArr[10'h130] = 8'hC0;
        memArr[10'h140] = 8'h50;
        memArr[10'h141] = 8'h12;
        memArr[10'h142] = 8'hAA;
        memArr[10'h143] = 8'hBB;
        memArr[10'h144] = 8'hCC;
        memArr[10'h145] = 8'hDD;
        memArr[10'h150] = 8'h80;
        memArr[10'h151] = 8'h00;
        memArr[10'h152] = 8'h02;

        rst_n      = 1'b0;
        pc_load    = 1'b0;
        new_pc     = '0;
        waitStates = 0;
        errEn      = 1'b0;
        errAddr    = '0;
        tick();
        tick();
        chk("rst_pc", pc, 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_rA", 64'(rA), 64'hF);
        chk("rst_rB", 64'(rB), 64'hF);
        chk("rst_icode", 64'(icode), 64'd0);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);

        // nop at 0, zero-wait
        rst_n = 1'b1;
        waitValid(20, cyc);
        chk("nop_lat", 64'(cyc), 64'd2);
        chk("nop_icode", 64'(icode), 64'd1);
        chk("nop_valP", valP, 64'd1);
        chk("nop_stat", 64'(stat), 64'd1);
        chk("nop_rA", 64'(rA), 64'hF);

        pcLoad(64'd1);
        chk("ld1_pc", pc, 64'd1);
        chk("ld1_valid", 64'(instr_valid), 64'd0);
        chk("ld1_req", 64'(mem_req), 64'd1);
        chk("ld1_addr", mem_addr, 64'd1);

        // jmp at 1
        waitValid(40, cyc);
        chk("jmp_lat", 64'(cyc), 64'd9);
        chk("jmp_icode", 64'(icode), 64'd7);
        chk("jmp_ifun", 64'(ifun), 64'd0);
        chk("jmp_rA", 64'(rA), 64'hF);
        chk("jmp_rB", 64'(rB), 64'hF);
        chk("jmp_valC", valC, 64'h40);
        chk("jmp_valP", valP, 64'h0A);
        chk("jmp_stat", 64'(stat), 64'd1);
        pcLoad(64'h40);
        chk("jmp_pc", pc, 64'h40);

        // addq %rcx,%rdx at 0x40
        waitValid(20, cyc);
        chk("opq_lat", 64'(cyc), 64'd2);
        chk("opq_icode", 64'(icode), 64'd6);
        chk("opq_rA", 64'(rA), 64'd1);
        chk("opq_rB", 64'(rB), 64'd2);
        chk("opq_valC", valC, 64'd0);
        chk("opq_valP", valP, 64'h42);

        // irmovq at 0x100 with two wait cycles per byte; pc_load mid-fetch ignored
        waitStates = 2;
        pcLoad(64'h100);
        pc_load = 1'b1;
        new_pc  = 64'hDEAD;
        tick();
        tick();
        tick();
        pc_load = 1'b0;
        chk("irm_pc_hold", pc, 64'h100);
        chk("irm_addr", mem_addr, 64'h101);
        waitValid(100, cyc);
        chk("irm_lat", 64'(cyc + 3), 64'd30);
        chk("irm_icode", 64'(icode), 64'd3);
        chk("irm_rA", 64'(rA), 64'hF);
        chk("irm_rB", 64'(rB), 64'd3);
        chk("irm_valC", valC, 64'h1122334455667788);
        chk("irm_valP", valP, 64'h10A);
        chk("irm_stat", 64'(stat), 64'd1);

        // halt at 0x120
        waitStates = 0;
        pcLoad(64'h120);
        waitValid(20, cyc);
        chk("hlt_lat", 64'(cyc), 64'd1);
        chk("hlt_stat", 64'(stat), 64'd2);
        chk("hlt_req", 64'(mem_req), 64'd0);
        chk("hlt_valP", valP, 64'h121);
        pc_load = 1'b1;
        new_pc  = 64'h0;
        tick();
        tick();
        tick();
        pc_load = 1'b0;
        chk("hlt_pc_hold", pc, 64'h120);
        chk("hlt_req_hold", 64'(mem_req), 64'd0);
        chk("hlt_stat_hold", 64'(stat), 64'd2);
        chk("hlt_valid_hold", 64'(instr_valid), 64'd1);

        // invalid opcode at 0x130
        doReset();
        chk("rst2_pc", pc, 64'd0);
        waitValid(20, cyc);
        pcLoad(64'h130);
        waitValid(20, cyc);
        chk("ins_lat", 64'(cyc), 64'd1);
        chk("ins_stat", 64'(stat), 64'd4);
        chk("ins_icode", 64'(icode), 64'hC);
        chk("ins_valP", valP, 64'h131);
        tick();
        chk("ins_req", 64'(mem_req), 64'd0);

        // mrmovq at 0x140, address error on byte 5
        doReset();
        waitValid(20, cyc);
        waitStates = 1;
        errEn      = 1'b1;
        errAddr    = 64'h145;
        pcLoad(64'h140);
        waitValid(100, cyc);
        chk("adr_lat", 64'(cyc), 64'd12);
        chk("adr_stat", 64'(stat), 64'd3);
        chk("adr_icode", 64'(icode), 64'd5);
        chk("adr_rA", 64'(rA), 64'd1);
        chk("adr_rB", 64'(rB), 64'd2);
        chk("adr_valC", valC, 64'h0000_0000_00CC_BBAA);
        tick();
        tick();
        tick();
        chk("adr_req", 64'(mem_req), 64'd0);
        chk("adr_valid", 64'(instr_valid), 64'd1);
        errEn      = 1'b0;
        waitStates = 0;

        // call at 0x150, asynchronous reset during byte 4
        doReset();
        waitValid(20, cyc);
        pcLoad(64'h150);
        tick();
        tick();
        tick();
        tick();
        chk("call_addr4", mem_addr, 64'h154);
        chk("call_req4", 64'(mem_req), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 64'(mem_req), 64'd0);
        chk("arst_pc", pc, 64'd0);
        chk("arst_valid", 64'(instr_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("refetch_req", 64'(mem_req), 64'd1);
        chk("refetch_addr", mem_addr, 64'd0);
        waitValid(20, cyc);
        chk("refetch_lat", 64'(cyc), 64'd1);
        chk("refetch_icode", 64'(icode), 64'd1);
        chk("refetch_valP", valP, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
